// File: rtl/cpu_types_pkg.sv
// Shared datapath/memory types: word type, arbiter FSM states and the
// wait-counter sizing used for the RAM timeout.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        DACC,
        IACC
    } arb_state_t;

    function automatic int wcnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

    localparam int TIMEOUT_DEF = 255;
    localparam int WCNT_W_DEF  = wcnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/dp_mem_arbiter_if.sv
// Datapath cache port plus single-ported RAM port seen by the memory arbiter.
interface dp_mem_arbiter_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  halt;
    logic  ihit;
    logic  dhit;
    word_t imemload;
    word_t dmemload;
    logic  ramREN;
    logic  ramWEN;
    word_t ramaddr;
    word_t ramstore;
    word_t ramload;
    logic  ramready;
    logic  err;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        input  ramload, ramready,
        output ihit, dhit, imemload, dmemload,
        output ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        output ramload, ramready,
        input  ihit, dhit, imemload, dmemload,
        input  ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface

// File: rtl/dp_mem_arbiter.sv
// Serialises fetch and data requests onto one variable-latency RAM port,
// data first, returning single-cycle hit pulses with registered load data.
module dp_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            CLK,
    input  logic            nRST,
    dp_mem_arbiter_if.slave mif
);

    localparam int            CW   = wcnt_width(TIMEOUT);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    arb_state_t    state_q, state_d;
    logic          ihit_q, ihit_d, dhit_q, dhit_d;
    logic          wr_q, wr_d, err_q, err_d, dserved_q, dserved_d;
    word_t         addr_q, addr_d, store_q, store_d;
    word_t         iload_q, iload_d, dload_q, dload_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          dreq, ireq;

    // dserved blocks a completed data request still held high until the next fetch
    assign dreq = (mif.dmemREN | mif.dmemWEN) & ~dserved_q & ~mif.halt;
    assign ireq = mif.imemREN & ~mif.halt;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= IDLE;
            ihit_q    <= 1'b0;
            dhit_q    <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            dserved_q <= 1'b0;
            addr_q    <= '0;
            store_q   <= '0;
            iload_q   <= '0;
            dload_q   <= '0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            ihit_q    <= ihit_d;
            dhit_q    <= dhit_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            dserved_q <= dserved_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
            iload_q   <= iload_d;
            dload_q   <= dload_d;
            wcnt_q    <= wcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ihit_d    = 1'b0;
        dhit_d    = 1'b0;
        wr_d      = wr_q;
        err_d     = err_q;
        dserved_d = dserved_q;
        addr_d    = addr_q;
        store_d   = store_q;
        iload_d   = iload_q;
        dload_d   = dload_q;
        wcnt_d    = wcnt_q;
        case (state_q)
            IDLE: begin
                if (dreq) begin
                    state_d = DACC;
                    addr_d  = mif.dmemaddr;
                    store_d = mif.dmemstore;
                    wr_d    = mif.dmemWEN;
                    wcnt_d  = '0;
                end else if (ireq) begin
                    state_d = IACC;
                    addr_d  = mif.imemaddr;
                    wr_d    = 1'b0;
                    wcnt_d  = '0;
                end
            end
            DACC, IACC: begin
                if (mif.ramready) begin
                    state_d = IDLE;
                    if (state_q == DACC) begin
                        dhit_d    = 1'b1;
                        dserved_d = 1'b1;
                        if (!wr_q) dload_d = mif.ramload;
                    end else begin
                        ihit_d    = 1'b1;
                        iload_d   = mif.ramload;
                        dserved_d = 1'b0;
                    end
                end else begin
                    // saturate so a stalled RAM cannot wrap the counter
                    if (wcnt_q != TMAX) wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_d == TMAX) err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mif.ramREN   = (state_q == IACC) | ((state_q == DACC) & ~wr_q);
    assign mif.ramWEN   = (state_q == DACC) & wr_q;
    assign mif.ramaddr  = addr_q;
    assign mif.ramstore = store_q;
    assign mif.ihit     = ihit_q;
    assign mif.dhit     = dhit_q;
    assign mif.imemload = iload_q;
    assign mif.dmemload = dload_q;
    assign mif.err      = err_q;

endmodule
